motion_sequencer: RTL and testbench
===================================

# motion_sequencer

Parametrised program store and playback engine for the robot motion controller. Debounced save/delete pulses build a program of up to DEPTH instructions. Execute plays the program back in order, holding each instruction for STEP_TICKS clocks, with pause/resume and optional looping. Playback is non-destructive, so a program can be replayed without re-entry. It sits between the key debouncers and the torque/direction display decoders, and replaces the separate FSM, FIFO and countdown blocks.

## Interface
- DEPTH, 16: maximum program length in instructions; ≥2.
- INSTR_W, 4: instruction width; [1:0] direction, [INSTR_W-1:2] torque.
- STEP_TICKS, 50_000_000: clocks each instruction is held during playback; ≥2.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- save  in  1  single-cycle pulse; append data_in.
- delete  in  1  single-cycle pulse; remove the most recently saved entry.
- clear  in  1  single-cycle pulse; abort playback and empty the program.
- execute  in  1  single-cycle pulse; start, pause or resume.
- loop_mode  in  1  level; 1 means wrap to entry 0 after the last entry.
- data_in  in  INSTR_W  instruction to save.
- instr_out  out  INSTR_W  instruction currently playing; 0 when not valid.
- instr_valid  out  1  high in S_RUN only; drives the display enables.
- count  out  $clog2(DEPTH+1)  number of stored entries.
- play_idx  out  $clog2(DEPTH)  index of the entry playing or paused.
- empty, full  out  1  count==0, count==DEPTH.
- lights  out  3  one-hot state: [0] IDLE, [1] RUN, [2] PAUSE.

## Operation
- States: S_IDLE, S_RUN, S_PAUSE.
- Reset values: state S_IDLE, count 0, play_idx 0, timer 0, instr_out 0, instr_valid 0, lights 3'b001. Memory contents are don't-care.
- S_IDLE command priority: clear > delete > save > execute. Exactly one command is acted on per cycle; the others are dropped.
  - save with !full: mem[count] <= data_in, count+1.
  - save when full: ignored.
  - delete with !empty: count-1.
  - delete when empty: ignored.
  - clear: count <= 0.
  - execute with !empty: play_idx <= 0, timer <= 0, go to S_RUN.
  - execute when empty: ignored.
- S_RUN:
  - The timer increments each clock.
  - At timer==STEP_TICKS-1: timer <= 0.
    - If play_idx<count-1: play_idx+1.
    - Else if loop_mode: play_idx <= 0.
    - Else: go to S_IDLE with the program retained.
  - execute goes to S_PAUSE with timer and play_idx frozen.
  - clear goes to S_IDLE with count 0.
  - save and delete are ignored.
- S_PAUSE:
  - execute returns to S_RUN and continues from the frozen timer value.
  - clear goes to S_IDLE with count 0.
  - save and delete are ignored.
- loop_mode is sampled only at the last-entry boundary. Changing it mid-run affects the next wrap decision only.
- A clear or execute arriving in the same cycle as a step boundary wins over the boundary. The advance for that cycle is discarded.

## Timing
- All outputs are registered.
- instr_out/instr_valid update one cycle after the state or play_idx change that causes them.
- Each entry is valid for exactly STEP_TICKS cycles.
- A non-looping program of N entries spends N·STEP_TICKS cycles in S_RUN.
- A save is visible in count and empty/full on the next cycle. Back-to-back save pulses on consecutive cycles are each accepted.
- rst_n assertion forces reset values immediately, including mid-playback. Release is synchronised by the existing reset synchroniser upstream.

## Structure
- motion_pkg holds:
  - typedef enum logic [1:0] seq_state_t {S_IDLE, S_RUN, S_PAUSE};
  - direction constants DIR_FWD/DIR_REV/DIR_LEFT/DIR_RIGHT;
  - an instruction field-slicing helper.
- Sub-module step_timer(clk, rst_n, run, clr, done): counter of width $clog2(STEP_TICKS); done is high for one cycle at STEP_TICKS-1. The parent owns play_idx and the state register.
- Program memory is a flop array, DEPTH×INSTR_W, with no read-port latency assumptions beyond one registered output stage.

## Test plan
Benches use DEPTH=4 and STEP_TICKS=3.
- Fill and overflow: save 4'h1,4'h6,4'hB,4'hE, then a 5th save 4'h3 → count=4, full=1, mem unchanged; delete → count=3, full=0.
- One-shot playback: program {1,6,B}, loop_mode=0, execute:
  - instr_out is 1,6,B for 3 cycles each, instr_valid high for 9 cycles;
  - then S_IDLE, count still 3;
  - a second execute replays identically.
- Loop mode: program {2,5}, loop_mode=1, run 15 cycles → instr_out sequence 2,2,2,5,5,5,2,… and play_idx wraps 1→0; no return to S_IDLE.
- Pause/resume: execute at cycle 1 of entry 1 → lights=3'b100, instr_valid=0, play_idx=1 held 10 cycles; execute → entry 1 completes its remaining 2 cycles.
- Boundary collisions:
  - clear coincident with step_timer done during S_RUN → S_IDLE, count=0, no advance;
  - save+delete in the same S_IDLE cycle with count=2 → count=1.
- Async reset mid-run: drop rst_n for 2 ns between clock edges during S_RUN → outputs take reset values before the next edge; count=0, lights=3'b001.

Source files
------------

// File: rtl/motion_pkg.sv
// Shared types and helpers for the motion program sequencer.
// Holds the sequencer state encoding, direction codes and instruction field accessors.
package motion_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } seq_state_t;

  localparam logic [1:0] DIR_FWD   = 2'd0;
  localparam logic [1:0] DIR_REV   = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // Widest instruction the field helpers accept; narrower words are zero-extended by the caller.
  localparam int INSTR_W_MAX = 32;

  function automatic logic [1:0] instr_dir(input logic [INSTR_W_MAX-1:0] instr);
    return instr[1:0];
  endfunction

  function automatic logic [INSTR_W_MAX-3:0] instr_torque(input logic [INSTR_W_MAX-1:0] instr);
    return instr[INSTR_W_MAX-1:2];
  endfunction

  function automatic logic [2:0] state_lights(input seq_state_t s);
    case (s)
      S_RUN:   return 3'b010;
      S_PAUSE: return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

endpackage

// File: rtl/motion_sequencer_step_timer.sv
// Per-instruction hold timer: counts while run is high, wraps after STEP_TICKS-1.
// done flags the terminal count; the parent decides whether that count is acted on.
module step_timer #(
  parameter int STEP_TICKS = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic done
);

  localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [TW-1:0] LAST = TW'(STEP_TICKS - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Unqualified by run so the parent can freeze the timer on this very count without a loop.
  assign done = (cnt_q == LAST);

endmodule

// File: rtl/motion_sequencer.sv
// Program store and playback engine: builds a program from save/delete pulses and
// replays it one instruction per STEP_TICKS clocks, with pause/resume and looping.
module motion_sequencer
  import motion_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int INSTR_W    = 4,
  parameter int STEP_TICKS = 50_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       save,
  input  logic                       delete,
  input  logic                       clear,
  input  logic                       execute,
  input  logic                       loop_mode,
  input  logic [INSTR_W-1:0]         data_in,
  output logic [INSTR_W-1:0]         instr_out,
  output logic                       instr_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [$clog2(DEPTH)-1:0]   play_idx,
  output logic                       empty,
  output logic                       full,
  output logic [2:0]                 lights
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  seq_state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] play_idx_q, play_idx_d;
  logic empty_q, empty_d;
  logic full_q, full_d;
  logic [INSTR_W-1:0] instr_out_q, instr_out_d;
  logic instr_valid_q, instr_valid_d;

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic mem_we;
  logic timer_run;
  logic timer_clr;
  logic timer_done;

  step_timer #(
    .STEP_TICKS (STEP_TICKS)
  ) u_step_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (timer_run),
    .clr   (timer_clr),
    .done  (timer_done)
  );

  // Held at zero in idle so every playback starts a fresh hold period.
  assign timer_clr = (state_q == S_IDLE);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    play_idx_d = play_idx_q;
    mem_we     = 1'b0;
    timer_run  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clear) begin
          count_d = '0;
        end else if (delete) begin
          if (!empty_q) count_d = count_q - 1'b1;
        end else if (save) begin
          if (!full_q) begin
            mem_we  = 1'b1;
            count_d = count_q + 1'b1;
          end
        end else if (execute) begin
          if (!empty_q) begin
            play_idx_d = '0;
            state_d    = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (clear) begin
          state_d = S_IDLE;
          count_d = '0;
        end else if (execute) begin
          // The pause cycle still counts toward the hold, unless it lands on the boundary.
          timer_run = !timer_done;
          state_d   = S_PAUSE;
        end else begin
          timer_run = 1'b1;
          if (timer_done) begin
            if (int'(play_idx_q) + 1 < int'(count_q)) begin
              play_idx_d = play_idx_q + 1'b1;
            end else if (loop_mode) begin
              play_idx_d = '0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      S_PAUSE: begin
        if (clear) begin
          state_d = S_IDLE;
          count_d = '0;
        end else if (execute) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    empty_d       = (count_d == '0);
    full_d        = (count_d == CW'(DEPTH));
    instr_valid_d = (state_q == S_RUN);
    instr_out_d   = (state_q == S_RUN) ? mem_q[play_idx_q] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      play_idx_q    <= '0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      instr_out_q   <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      play_idx_q    <= play_idx_d;
      empty_q       <= empty_d;
      full_q        <= full_d;
      instr_out_q   <= instr_out_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Program contents survive reset; only count decides what is live.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[count_q[PW-1:0]] <= data_in;
    end
  end

  assign instr_out   = instr_out_q;
  assign instr_valid = instr_valid_q;
  assign count       = count_q;
  assign play_idx    = play_idx_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign lights      = state_lights(state_q);

endmodule

// File: tb/tb_motion_sequencer.sv
// Directed bench for motion_sequencer with DEPTH=4, STEP_TICKS=3.
module tb_motion_sequencer;

  localparam int DEPTH      = 4;
  localparam int INSTR_W    = 4;
  localparam int STEP_TICKS = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic save, delete, clear, execute, loop_mode;
  logic [INSTR_W-1:0] data_in;
  logic [INSTR_W-1:0] instr_out;
  logic instr_valid;
  logic [2:0] count;
  logic [1:0] play_idx;
  logic empty, full;
  logic [2:0] lights;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [INSTR_W-1:0] exp_q[$];

  motion_sequencer #(
    .DEPTH      (DEPTH),
    .INSTR_W    (INSTR_W),
    .STEP_TICKS (STEP_TICKS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .save        (save),
    .delete      (delete),
    .clear       (clear),
    .execute     (execute),
    .loop_mode   (loop_mode),
    .data_in     (data_in),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .count       (count),
    .play_idx    (play_idx),
    .empty       (empty),
    .full        (full),
    .lights      (lights)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_save(input logic [INSTR_W-1:0] d);
    data_in = d;
    save = 1'b1;
    cyc();
    save = 1'b0;
  endtask

  task automatic pulse_delete();
    delete = 1'b1;
    cyc();
    delete = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  task automatic pulse_exec();
    execute = 1'b1;
    cyc();
    execute = 1'b0;
  endtask

  task automatic play_expect(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      cyc();
      check({tag, "_valid"}, 32'(instr_valid), 1);
      if (exp_q.size() == 0) begin
        check({tag, "_expq_empty"}, 1, 0);
      end else begin
        check({tag, "_instr"}, 32'(instr_out), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic expect_idle(input int cnt, input string tag);
    check({tag, "_lights"}, 32'(lights), 32'h1);
    check({tag, "_valid"}, 32'(instr_valid), 0);
    check({tag, "_instr"}, 32'(instr_out), 0);
    check({tag, "_count"}, 32'(count), cnt);
  endtask

  initial begin
    rst_n = 1'b0;
    save = 1'b0; delete = 1'b0; clear = 1'b0; execute = 1'b0; loop_mode = 1'b0;
    data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    expect_idle(0, "reset");
    check("reset_play_idx", 32'(play_idx), 0);
    check("reset_empty", 32'(empty), 1);
    check("reset_full", 32'(full), 0);
    #3 rst_n = 1'b1;
    cyc();

    // fill and overflow
    pulse_save(4'h1); pulse_save(4'h6); pulse_save(4'hB); pulse_save(4'hE);
    check("fill_count", 32'(count), 4);
    check("fill_full", 32'(full), 1);
    check("fill_empty", 32'(empty), 0);
    pulse_save(4'h3);
    check("ovf_count", 32'(count), 4);
    check("ovf_full", 32'(full), 1);
    pulse_delete();
    check("del_count", 32'(count), 3);
    check("del_full", 32'(full), 0);

    // one-shot playback, then replay
    for (int r = 0; r < 2; r++) begin
      pulse_exec();
      check("shot_lights_run", 32'(lights), 32'h2);
      exp_q = '{4'h1, 4'h1, 4'h1, 4'h6, 4'h6, 4'h6, 4'hB, 4'hB, 4'hB};
      play_expect(9, "shot");
      cyc();
      expect_idle(3, "shot_end");
    end

    // execute on an empty program is ignored
    pulse_clear();
    check("clr_count", 32'(count), 0);
    check("clr_empty", 32'(empty), 1);
    pulse_exec();
    check("exec_empty_lights", 32'(lights), 32'h1);

    // loop mode
    pulse_save(4'h2); pulse_save(4'h5);
    loop_mode = 1'b1;
    pulse_exec();
    for (int k = 1; k <= 15; k++) begin
      cyc();
      check("loop_valid", 32'(instr_valid), 1);
      check("loop_instr", 32'(instr_out), ((((k - 1) / 3) % 2) == 1) ? 32'h5 : 32'h2);
      check("loop_idx", 32'(play_idx), (k / 3) % 2);
    end
    check("loop_lights", 32'(lights), 32'h2);
    loop_mode = 1'b0;
    pulse_clear();
    check("run_clr_lights", 32'(lights), 32'h1);
    check("run_clr_count", 32'(count), 0);

    // pause / resume on cycle 1 of entry 1
    pulse_save(4'h1); pulse_save(4'h6); pulse_save(4'hB);
    pulse_exec();
    repeat (3) cyc();
    check("pre_pause_idx", 32'(play_idx), 1);
    pulse_exec();
    check("pause_lights", 32'(lights), 32'h4);
    check("pause_idx", 32'(play_idx), 1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("pause_hold_lights", 32'(lights), 32'h4);
      check("pause_hold_valid", 32'(instr_valid), 0);
      check("pause_hold_idx", 32'(play_idx), 1);
    end
    pulse_exec();
    check("resume_lights", 32'(lights), 32'h2);
    check("resume_valid_lag", 32'(instr_valid), 0);
    exp_q = '{4'h6, 4'h6, 4'hB, 4'hB, 4'hB};
    play_expect(5, "resume");
    cyc();
    expect_idle(3, "resume_end");

    // clear coincident with the step boundary
    pulse_exec();
    repeat (2) cyc();
    pulse_clear();
    check("coll_lights", 32'(lights), 32'h1);
    check("coll_count", 32'(count), 0);
    check("coll_idx", 32'(play_idx), 0);
    check("coll_empty", 32'(empty), 1);

    // save and delete in the same idle cycle
    pulse_save(4'h7); pulse_save(4'h9);
    check("sd_pre_count", 32'(count), 2);
    data_in = 4'hC; save = 1'b1; delete = 1'b1;
    cyc();
    save = 1'b0; delete = 1'b0;
    check("sd_count", 32'(count), 1);

    // asynchronous reset mid-run
    loop_mode = 1'b1;
    pulse_exec();
    repeat (4) cyc();
    check("pre_rst_valid", 32'(instr_valid), 1);
    check("pre_rst_instr", 32'(instr_out), 32'h7);
    #2 rst_n = 1'b0;
    #2;
    expect_idle(0, "async_rst");
    check("async_rst_idx", 32'(play_idx), 0);
    rst_n = 1'b1;
    loop_mode = 1'b0;
    cyc();
    expect_idle(0, "post_rst");

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
